// File: rtl/register_arbiter_pkg.sv
// Shared types and constants for the register arbiter slice.
package register_arbiter_pkg;

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    localparam int unsigned DATA_W_DEFAULT = 7;

    // Index width that stays legal for a single-entry vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_arbiter_if.sv
// Request/grant bundle between the requesters and the register arbiter.
interface register_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = register_arbiter_pkg::DATA_W_DEFAULT
);
    localparam int unsigned IdxW = register_arbiter_pkg::idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         reg_din;
    logic                      reg_enable;
    logic [IdxW-1:0]           owner;
    logic                      busy;

    modport master (
        output req, req_data,
        input  gnt, done, reg_din, reg_enable, owner, busy
    );

    modport slave (
        input  req, req_data,
        output gnt, done, reg_din, reg_enable, owner, busy
    );

endinterface

// File: rtl/register_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr, with wrap.
module rr_picker
    import register_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    int unsigned      idx;
    logic [IDX_W-1:0] sel;

    // Walk offsets from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            sel = IDX_W'(idx);
            if (req[sel]) begin
                any    = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/register_arbiter.sv
// Round-robin owner of the shared display register: fixed hold window, then a one-cycle clear gap.
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input logic              clock,
    input logic              reset_n,
    register_arbiter_if.slave bus
);

    localparam int unsigned     IdxW    = idx_width(NUM_REQ);
    localparam int unsigned     CntW    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(HOLD_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;

    logic                pick_any;
    logic [IdxW-1:0]     pick_idx;
    logic                owner_req;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_picker (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign owner_req = bus.req[owner_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = '0;
        gnt_d   = '0;
        done_d  = '0;
        din_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        unique case (state_q)
            StHold: begin
                // Completion or abandon both release the register and rotate past the owner.
                if ((cnt_q == LastCnt) || !owner_req) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    ptr_d   = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
                end else begin
                    state_d = StHold;
                    cnt_d   = cnt_q + 1'b1;
                    owner_d = owner_q;
                    gnt_d   = gnt_q;
                    din_d   = din_q;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = (cnt_d == LastCnt) ? gnt_q : '0;
                end
            end
            default: begin
                if (pick_any) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    owner_d = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    din_d   = bus.req_data[pick_idx*DATA_W +: DATA_W];
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = (HOLD_CYCLES == 1) ? gnt_d : '0;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            din_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            din_q   <= din_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.reg_din    = din_q;
    assign bus.reg_enable = en_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = busy_q;

endmodule
